sdram_port_arbiter: RTL

Shares the single host port of the SDRAM controller between NUM_PORTS requesters, e.g. port 0 video fetch, port 1 CPU, port 2 DMA/loader. The block arbitrates between requests and latches the winning command. It drives the controller's request/address/data lines with the hold timing the controller needs, and returns read data, read-valid and an acknowledge to the granted port. It sits between the requesters and the SDRAM controller in clk_sys.

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_arb_pick.sv | 38 +++
 rtl/sdram_port_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM host-port arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned RUN_W  = 3;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone
  } arb_state_e;

  // Round-robin successor among ports 1..num_ports-1; port 0 never holds the pointer.
  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] last,
                                               input int unsigned num_ports);
    if (32'(last) + 32'd1 >= num_ports) return IDX_W'(1);
    return last + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select: port 0 first, then ports 1..N-1 searched from rr_ptr upward.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  localparam int unsigned CW = IDX_W + 1;

  logic [7:0]    req_ext;
  logic [CW-1:0] cand;

  // A frozen rr_ptr of 1 degenerates to plain lowest-index-wins.
  always_comb begin
    req_ext = 8'(req);
    idx     = '0;
    valid   = 1'b0;
    cand    = '0;
    if (req_ext[0]) begin
      valid = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS - 1; k++) begin
        cand = {1'b0, rr_ptr} + CW'(k);
        if (cand >= CW'(NUM_PORTS)) cand = cand - CW'(NUM_PORTS - 1);
        if (!valid && req_ext[cand]) begin
          valid = 1'b1;
          idx   = cand[IDX_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller host port between NUM_PORTS requesters.
// Define SDRAM_ARB_RR_EN for round-robin among ports 1..N-1 (port 0 always first).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned MIN_BUSY  = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]        port_ack,
  output logic [NUM_PORTS-1:0]        port_err,
  output logic [NUM_PORTS-1:0]        port_rvalid,
  output logic [DATA_W-1:0]           port_rdata,
  output logic                        host_wr_req,
  output logic                        host_rd_req,
  output logic [ADDR_W-1:0]           host_addr,
  output logic [DATA_W-1:0]           host_data_in,
  input  logic [DATA_W-1:0]           host_data_out,
  input  logic                        host_busy,
  input  logic                        host_rd_valid,
  output logic [IDX_W-1:0]            grant_idx
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   grant;

  sdram_arb_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req    (port_req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // The cycle showing a completion pulse is a dead IDLE cycle, so a requester that holds
  // req until it sees ack is never granted twice for one request.
  assign grant = (state_q == StIdle) && !host_busy && pick_valid && !(|ack_q) && !(|err_q);

`ifdef SDRAM_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant && (pick_idx != '0)) rr_ptr_d = next_rr(pick_idx, NUM_PORTS);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= IDX_W'(1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = IDX_W'(1);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;
    run_d    = run_q;
    ack_d    = '0;
    err_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;

    case (state_q)
      StIdle: begin
        if (grant) begin
          idx_d   = pick_idx;
          we_d    = port_we[pick_idx];
          addr_d  = port_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = port_wdata[pick_idx*DATA_W +: DATA_W];
          tmo_d   = '0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (host_busy) begin
          // The busy cycle seen here is the first cycle of the run.
          run_d   = RUN_W'(1);
          state_d = StWaitDone;
        end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
          err_d[idx_q] = 1'b1;
          state_d      = StIdle;
        end
      end

      StWaitDone: begin
        if (host_busy) begin
          if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
        end else if (run_q < RUN_W'(MIN_BUSY)) begin
          // Too short to be ours: a refresh, so present the request again.
          state_d = StIssue;
        end else begin
          ack_d[idx_q] = 1'b1;
          if (!we_q && host_rd_valid) begin
            rvalid_d[idx_q] = 1'b1;
            rdata_d         = host_data_out;
          end
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
      run_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
      run_q    <= run_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Gated with busy so the request falls in the same cycle busy does.
  assign host_rd_req = !we_q && ((state_q == StIssue) || ((state_q == StWaitDone) && host_busy));
  assign host_wr_req = we_q && ((state_q == StIssue) || ((state_q == StWaitDone) && host_busy));

  assign port_ack     = ack_q;
  assign port_err     = err_q;
  assign port_rvalid  = rvalid_q;
  assign port_rdata   = rdata_q;
  assign host_addr    = addr_q;
  assign host_data_in = wdata_q;
  assign grant_idx    = idx_q;

endmodule
